// File: rtl/exe_alu_arbiter_if.sv
// exe_alu_arbiter_if: requester, ALU and response bundle of the shared ALU arbiter.
// slave = arbiter side; master = two requesters plus the combinational ALU.
interface exe_alu_arbiter_if #(
  parameter int XLEN  = 64,
  parameter int ALU_W = 12,
  parameter int BJ_W  = 8,
  parameter int TAG_W = 4
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*XLEN-1:0]  req_op1;
  logic [2*XLEN-1:0]  req_op2;
  logic [2*ALU_W-1:0] req_alu;
  logic [1:0]         req_word;
  logic [2*TAG_W-1:0] req_tag;

  logic [XLEN-1:0]    alu_op1;
  logic [XLEN-1:0]    alu_op2;
  logic [ALU_W-1:0]   alu_info;
  logic               alu_is_word;
  logic [XLEN-1:0]    alu_result;
  logic [BJ_W-1:0]    alu_bj;

  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [2*XLEN-1:0]  rsp_data;
  logic [2*BJ_W-1:0]  rsp_bj;
  logic [2*TAG_W-1:0] rsp_tag;

  modport slave (
    input  req_valid, req_op1, req_op2,
    input  req_alu, req_word, req_tag,
    output req_ready,
    output alu_op1, alu_op2,
    output alu_info, alu_is_word,
    input  alu_result, alu_bj,
    output rsp_valid, rsp_data,
    output rsp_bj, rsp_tag,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_op1, req_op2,
    output req_alu, req_word, req_tag,
    input  req_ready,
    input  alu_op1, alu_op2,
    input  alu_info, alu_is_word,
    output alu_result, alu_bj,
    input  rsp_valid, rsp_data,
    input  rsp_bj, rsp_tag,
    output rsp_ready
  );
endinterface

// File: rtl/exe_alu_arbiter.sv
// exe_alu_arbiter: round-robin share of the combinational EX ALU between
// port 0 (pipeline) and port 1 (aux unit), with issue reg and per-port rsp buffers.
// Ports: clk, rst (sync, active-low), flush (sync kill), bus (slave modport).
module exe_alu_arbiter #(
  parameter int XLEN  = 64,
  parameter int ALU_W = 12,
  parameter int BJ_W  = 8,
  parameter int TAG_W = 4
) (
  input logic              clk,
  input logic              rst,
  input logic              flush,
  exe_alu_arbiter_if.slave bus
);

  logic [1:0][XLEN-1:0]  req_op1_v;
  logic [1:0][XLEN-1:0]  req_op2_v;
  logic [1:0][ALU_W-1:0] req_alu_v;
  logic [1:0][TAG_W-1:0] req_tag_v;

  assign req_op1_v = bus.req_op1;
  assign req_op2_v = bus.req_op2;
  assign req_alu_v = bus.req_alu;
  assign req_tag_v = bus.req_tag;

  logic [1:0]       busy_q, busy_d;
  logic             rr_q, rr_d;

  logic             iss_valid_q, iss_valid_d;
  logic [XLEN-1:0]  iss_op1_q, iss_op1_d;
  logic [XLEN-1:0]  iss_op2_q, iss_op2_d;
  logic [ALU_W-1:0] iss_alu_q, iss_alu_d;
  logic             iss_word_q, iss_word_d;
  logic [TAG_W-1:0] iss_tag_q, iss_tag_d;
  logic             iss_src_q, iss_src_d;

  logic [1:0]             rsp_valid_q, rsp_valid_d;
  logic [1:0][XLEN-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0][BJ_W-1:0]   rsp_bj_q, rsp_bj_d;
  logic [1:0][TAG_W-1:0]  rsp_tag_q, rsp_tag_d;

  logic [1:0] eligible;
  logic [1:0] grant;
  logic       gnt_port;
  logic [1:0] pop;

  // rst gating keeps req_ready low while reset is held
  assign eligible = bus.req_valid & ~busy_q
                  & {2{~flush & rst}};

  always_comb begin
    grant = 2'b00;
    unique case (eligible)
      2'b11:   grant = rr_q ? 2'b10 : 2'b01;
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign gnt_port      = grant[1];
  assign bus.req_ready = grant;
  assign pop           = rsp_valid_q & bus.rsp_ready;

  // idle issue slot presents a null op so the ALU outputs 0
  assign bus.alu_op1     = iss_valid_q ? iss_op1_q  : '0;
  assign bus.alu_op2     = iss_valid_q ? iss_op2_q  : '0;
  assign bus.alu_info    = iss_valid_q ? iss_alu_q  : '0;
  assign bus.alu_is_word = iss_valid_q ? iss_word_q : 1'b0;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_bj    = rsp_bj_q;
  assign bus.rsp_tag   = rsp_tag_q;

  always_comb begin
    busy_d      = busy_q;
    rr_d        = rr_q;
    iss_valid_d = 1'b0;
    iss_op1_d   = iss_op1_q;
    iss_op2_d   = iss_op2_q;
    iss_alu_d   = iss_alu_q;
    iss_word_d  = iss_word_q;
    iss_tag_d   = iss_tag_q;
    iss_src_d   = iss_src_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_bj_d    = rsp_bj_q;
    rsp_tag_d   = rsp_tag_q;

    if (flush) begin
      // in-flight op is dropped; rr survives
      busy_d      = 2'b00;
      rsp_valid_d = 2'b00;
    end else begin
      rsp_valid_d = rsp_valid_q & ~pop;
      busy_d      = busy_q & ~pop;

      // busy guarantees the target buffer is empty,
      // so a landing result never meets a pop
      if (iss_valid_q) begin
        rsp_valid_d[iss_src_q] = 1'b1;
        rsp_data_d[iss_src_q]  = bus.alu_result;
        rsp_bj_d[iss_src_q]    = bus.alu_bj;
        rsp_tag_d[iss_src_q]   = iss_tag_q;
      end

      if (|grant) begin
        iss_valid_d = 1'b1;
        iss_op1_d   = req_op1_v[gnt_port];
        iss_op2_d   = req_op2_v[gnt_port];
        iss_alu_d   = req_alu_v[gnt_port];
        iss_word_d  = bus.req_word[gnt_port];
        iss_tag_d   = req_tag_v[gnt_port];
        iss_src_d   = gnt_port;
        busy_d      = busy_d | grant;
        rr_d        = ~gnt_port;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q      <= '0;
      rr_q        <= 1'b0;
      iss_valid_q <= 1'b0;
      iss_op1_q   <= '0;
      iss_op2_q   <= '0;
      iss_alu_q   <= '0;
      iss_word_q  <= 1'b0;
      iss_tag_q   <= '0;
      iss_src_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_bj_q    <= '0;
      rsp_tag_q   <= '0;
    end else begin
      busy_q      <= busy_d;
      rr_q        <= rr_d;
      iss_valid_q <= iss_valid_d;
      iss_op1_q   <= iss_op1_d;
      iss_op2_q   <= iss_op2_d;
      iss_alu_q   <= iss_alu_d;
      iss_word_q  <= iss_word_d;
      iss_tag_q   <= iss_tag_d;
      iss_src_q   <= iss_src_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_bj_q    <= rsp_bj_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

endmodule

// File: tb/tb_exe_alu_arbiter.sv
// tb_exe_alu_arbiter: directed + random bench for exe_alu_arbiter
// against a transaction-level model of the two requesters.
module tb_exe_alu_arbiter;
  localparam int XLEN  = 64;
  localparam int ALU_W = 12;
  localparam int BJ_W  = 8;
  localparam int TAG_W = 4;

  localparam logic [11:0] OP_ADD  = 12'h001;
  localparam logic [11:0] OP_SUB  = 12'h002;
  localparam logic [11:0] OP_SLTU = 12'h008;
  localparam logic [11:0] OP_XOR  = 12'h010;
  localparam logic [11:0] OP_OR   = 12'h020;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  exe_alu_arbiter_if #(
    .XLEN(XLEN), .ALU_W(ALU_W),
    .BJ_W(BJ_W), .TAG_W(TAG_W)
  ) bus ();

  exe_alu_arbiter #(
    .XLEN(XLEN), .ALU_W(ALU_W),
    .BJ_W(BJ_W), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst),
    .flush(flush), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // environment ALU: returns {bj, result}
  function automatic logic [71:0] alu_fn(
    input logic [11:0] op, input logic [63:0] a,
    input logic [63:0] b, input logic w);
    logic [63:0] r;
    logic [7:0]  bj;
    r = '0;
    case (op)
      12'h001: r = a + b;
      12'h002: r = a - b;
      12'h004: r = {63'd0, $signed(a) < $signed(b)};
      12'h008: r = {63'd0, a < b};
      12'h010: r = a ^ b;
      12'h020: r = a | b;
      12'h040: r = a & b;
      12'h080: r = a << b[5:0];
      12'h100: r = a >> b[5:0];
      12'h200: r = $signed(a) >>> b[5:0];
      12'h400: r = a + 64'd4;
      12'h800: r = b - a;
      default: r = '0;
    endcase
    if (w) r = {{32{r[31]}}, r[31:0]};
    bj = (op == 12'h0) ? 8'd0 :
         {op[11:8], a == b, a != b,
          $signed(a) < $signed(b), a < b};
    return {bj, r};
  endfunction

  always_comb
    {bus.alu_bj, bus.alu_result} =
      alu_fn(bus.alu_info, bus.alu_op1,
             bus.alu_op2, bus.alu_is_word);

  // ---- transaction model ----
  // stage: 0 none, 1 in ALU, 2 waiting to be consumed
  typedef struct {
    int          stage;
    logic [63:0] op1, op2, res;
    logic [11:0] alu;
    logic        word;
    logic [3:0]  tag;
    logic [7:0]  bj;
  } rec_t;

  rec_t        m_rec[2];
  logic [63:0] m_sd[2];
  logic [7:0]  m_sbj[2];
  logic [3:0]  m_stag[2];
  logic        m_rr;
  bit          m_known = 0;

  function automatic logic [1:0] exp_grant(
    input logic [1:0] v, input logic rr,
    input logic fl, input logic rs);
    logic [1:0] e;
    e[0] = v[0] && m_rec[0].stage == 0 && !fl && rs;
    e[1] = v[1] && m_rec[1].stage == 0 && !fl && rs;
    if (e == 2'b11) return rr ? 2'b10 : 2'b01;
    return e;
  endfunction

  always @(posedge clk) begin
    logic [1:0] g;
    int p;
    g = exp_grant(bus.req_valid, m_rr, flush, rst);
    if (!rst) begin
      m_known = 1;
      m_rr = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_rec[i].stage = 0;
        m_sd[i] = '0; m_sbj[i] = '0; m_stag[i] = '0;
      end
    end else if (m_known) begin
      if (flush) begin
        for (int i = 0; i < 2; i++) m_rec[i].stage = 0;
      end else begin
        for (int i = 0; i < 2; i++)
          if (m_rec[i].stage == 2 && bus.rsp_ready[i])
            m_rec[i].stage = 0;
        for (int i = 0; i < 2; i++)
          if (m_rec[i].stage == 1) begin
            m_rec[i].stage = 2;
            m_sd[i]   = m_rec[i].res;
            m_sbj[i]  = m_rec[i].bj;
            m_stag[i] = m_rec[i].tag;
          end
        if (g != 2'b00) begin
          p = g[1] ? 1 : 0;
          m_rec[p].stage = 1;
          m_rec[p].op1  = bus.req_op1[p*XLEN +: XLEN];
          m_rec[p].op2  = bus.req_op2[p*XLEN +: XLEN];
          m_rec[p].alu  = bus.req_alu[p*ALU_W +: ALU_W];
          m_rec[p].word = bus.req_word[p];
          m_rec[p].tag  = bus.req_tag[p*TAG_W +: TAG_W];
          {m_rec[p].bj, m_rec[p].res} =
            alu_fn(m_rec[p].alu, m_rec[p].op1,
                   m_rec[p].op2, m_rec[p].word);
          m_rr = (p == 0);
        end
      end
    end
  end

  // compare DUT against model every cycle, mid-cycle
  always @(negedge clk) begin
    int ip;
    if (m_known) begin
      chk("req_ready", bus.req_ready,
          exp_grant(bus.req_valid, m_rr, flush, rst));
      ip = -1;
      for (int i = 0; i < 2; i++)
        if (m_rec[i].stage == 1) ip = i;
      chk("alu_info", bus.alu_info,
          ip >= 0 ? m_rec[ip].alu : 12'h0);
      chk("alu_op1", bus.alu_op1,
          ip >= 0 ? m_rec[ip].op1 : 64'h0);
      chk("alu_op2", bus.alu_op2,
          ip >= 0 ? m_rec[ip].op2 : 64'h0);
      chk("alu_word", bus.alu_is_word,
          ip >= 0 ? m_rec[ip].word : 1'b0);
      for (int i = 0; i < 2; i++) begin
        chk("rsp_valid", bus.rsp_valid[i],
            m_rec[i].stage == 2);
        chk("rsp_data", bus.rsp_data[i*XLEN +: XLEN], m_sd[i]);
        chk("rsp_bj", bus.rsp_bj[i*BJ_W +: BJ_W], m_sbj[i]);
        chk("rsp_tag", bus.rsp_tag[i*TAG_W +: TAG_W], m_stag[i]);
      end
    end
  end

  // ---- stimulus ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p,
    input logic [63:0] a, input logic [63:0] b,
    input logic [11:0] op, input logic w,
    input logic [3:0] tag);
    bus.req_op1[p*XLEN +: XLEN]   = a;
    bus.req_op2[p*XLEN +: XLEN]   = b;
    bus.req_alu[p*ALU_W +: ALU_W] = op;
    bus.req_word[p]               = w;
    bus.req_tag[p*TAG_W +: TAG_W] = tag;
  endtask

  initial begin
    logic [71:0] pin;
    logic [11:0] one;
    logic [63:0] a;
    int gq[$];
    int p0g;
    bit seen;

    bus.req_valid = '0; bus.rsp_ready = '0;
    bus.req_op1 = '0; bus.req_op2 = '0;
    bus.req_alu = '0; bus.req_word = '0;
    bus.req_tag = '0;

    // model pins
    pin = alu_fn(OP_ADD, 64'd5, 64'd7, 1'b0);
    chk("pin_add", pin[63:0], 64'd12);
    pin = alu_fn(OP_ADD, 64'h7fffffff, 64'd1, 1'b1);
    chk("pin_word", pin[63:0], 64'hffffffff80000000);
    pin = alu_fn(OP_SLTU, 64'd1, 64'd2, 1'b0);
    chk("pin_sltu", pin[63:0], 64'd1);

    // reset held two cycles
    tick();
    bus.req_valid = 2'b11;
    #1;
    chk("rst_rdy", bus.req_ready, 2'b00);
    chk("rst_rv", bus.rsp_valid, 2'b00);
    chk("rst_info", bus.alu_info, 12'h0);
    tick();
    chk("rst_rdy2", bus.req_ready, 2'b00);
    rst = 1'b1;
    bus.req_valid = 2'b00;
    tick();

    // single ADD on port 0
    set_req(0, 64'd5, 64'd7, OP_ADD, 1'b0, 4'd3);
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b01;
    #1;
    chk("add_rdy", bus.req_ready, 2'b01);
    tick();
    chk("add_busy1", bus.req_ready, 2'b00);
    chk("add_aluop1", bus.alu_op1, 64'd5);
    chk("add_info", bus.alu_info, OP_ADD);
    tick();
    chk("add_rv", bus.rsp_valid, 2'b01);
    chk("add_data", bus.rsp_data[63:0], 64'd12);
    chk("add_tag", bus.rsp_tag[3:0], 4'd3);
    chk("add_busy2", bus.req_ready, 2'b00);
    tick();
    chk("add_popped", bus.rsp_valid, 2'b00);
    chk("add_reacc", bus.req_ready, 2'b01);
    bus.req_valid = 2'b00;
    tick();

    // contention from rr = 0
    rst = 1'b0; tick(); rst = 1'b1;
    set_req(0, 64'd10, 64'd3, OP_SUB, 1'b0, 4'd1);
    set_req(1, 64'd1, 64'd2, OP_SLTU, 1'b0, 4'd2);
    bus.req_valid = 2'b11;
    for (int k = 0; k < 9; k++) begin
      #1;
      if (bus.req_ready != 2'b00)
        gq.push_back(int'(bus.req_ready[1]));
      tick();
    end
    bus.req_valid = 2'b00;
    repeat (4) tick();
    chk("cont_ngrants", gq.size() >= 4, 1'b1);
    for (int k = 0; k < 4 && k < gq.size(); k++)
      chk("cont_order", gq[k], k % 2);
    chk("cont_d0", bus.rsp_data[63:0], 64'd7);
    chk("cont_d1", bus.rsp_data[127:64], 64'd1);

    // backpressure on port 1
    set_req(1, 64'd100, 64'd23, OP_ADD, 1'b0, 4'd9);
    set_req(0, 64'h55, 64'h0f, OP_XOR, 1'b0, 4'd4);
    bus.rsp_ready = 2'b01;
    bus.req_valid = 2'b11;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      seen = bus.rsp_valid[1];
    end
    chk("bp_land", seen, 1'b1);
    p0g = 0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", bus.rsp_data[127:64], 64'd123);
      chk("bp_rdy1", bus.req_ready[1], 1'b0);
      p0g += int'(bus.req_ready[0]);
      tick();
    end
    chk("bp_p0_issues", p0g > 0, 1'b1);
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b10;
    #1;
    chk("bp_pop_rdy", bus.req_ready[1], 1'b0);
    tick();
    chk("bp_reacc", bus.req_ready, 2'b10);
    bus.req_valid = 2'b00;
    repeat (4) tick();

    // word op on port 1
    set_req(1, 64'h7fffffff, 64'd1, OP_ADD, 1'b1, 4'd5);
    bus.req_valid = 2'b10;
    tick();
    bus.req_valid = 2'b00;
    tick();
    chk("word_rv", bus.rsp_valid[1], 1'b1);
    chk("word_data", bus.rsp_data[127:64],
        64'hffffffff80000000);
    repeat (3) tick();

    // flush with ISS = port 0 and rsp_valid[1] = 1
    set_req(1, 64'hf0, 64'h0f, OP_OR, 1'b0, 4'd6);
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b10;
    tick();
    set_req(0, 64'd1, 64'd1, OP_ADD, 1'b0, 4'd2);
    bus.req_valid = 2'b01;
    tick();
    chk("fl_pre_rv", bus.rsp_valid, 2'b10);
    chk("fl_pre_info", bus.alu_info, OP_ADD);
    flush = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    chk("fl_rdy", bus.req_ready, 2'b00);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_rv", bus.rsp_valid, 2'b00);
    chk("fl_info", bus.alu_info, 12'h0);
    chk("fl_reacc", bus.req_ready, 2'b10);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    repeat (3) tick();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < 2; p++) begin
        one = 12'h001;
        one = one << $urandom_range(0, 11);
        a = {$urandom, $urandom};
        set_req(p, a,
          ($urandom_range(0, 7) == 0) ? a :
            {$urandom, $urandom},
          one, 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)));
      end
      bus.req_valid = 2'($urandom_range(0, 3));
      bus.rsp_ready = 2'($urandom_range(0, 3)) |
                      2'($urandom_range(0, 3));
      flush = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 299) != 0);
      tick();
    end

    rst = 1'b1; flush = 1'b0;
    bus.req_valid = 2'b00;
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
